// File: rtl/univ_shift_reg.sv
// Universal register: parallel load or N-position shift, one step per clock.
// Define ROTATE_EN to make mode 11 rotate right; otherwise it is a no-op.
module univ_shift_reg #(
  parameter int WIDTH = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  localparam int CW = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_mode,
  input  logic [CW-1:0]    cmd_count,
  input  logic [WIDTH-1:0] p_in,
  input  logic             s_in_l,
  input  logic             s_in_r,
  output logic [WIDTH-1:0] p_out,
  output logic             s_out_l,
  output logic             s_out_r,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  localparam logic [1:0] M_LOAD = 2'b00;
  localparam logic [1:0] M_SHR  = 2'b01;
  localparam logic [1:0] M_SHL  = 2'b10;
  localparam logic [1:0] M_ROR  = 2'b11;

  state_t           state, state_d;
  logic [WIDTH-1:0] data, data_d, stepped;
  logic [CW-1:0]    remaining, rem_d;
  logic [1:0]       mode, mode_d;
  logic             rot_ok;

`ifdef ROTATE_EN
  assign rot_ok = 1'b1;
`else
  // Without rotate, mode 11 is accepted but completes immediately.
  assign rot_ok = (cmd_mode != M_ROR);
`endif

  always_comb begin
    stepped = data;
    unique case (mode)
      M_SHR: stepped = {s_in_l, data[WIDTH-1:1]};
      M_SHL: stepped = {data[WIDTH-2:0], s_in_r};
`ifdef ROTATE_EN
      M_ROR: stepped = {data[0], data[WIDTH-1:1]};
`endif
      default: stepped = data;
    endcase
  end

  always_comb begin
    state_d = state;
    data_d  = data;
    rem_d   = remaining;
    mode_d  = mode;
    unique case (state)
      IDLE: begin
        if (cmd_valid) begin
          if (cmd_mode == M_LOAD) begin
            data_d  = p_in;
            state_d = DONE;
          end else if (cmd_count != '0 && rot_ok) begin
            mode_d  = cmd_mode;
            rem_d   = cmd_count;
            state_d = SHIFT;
          end else begin
            state_d = DONE;
          end
        end
      end
      SHIFT: begin
        data_d = stepped;
        rem_d  = remaining - CW'(1);
        if (remaining == CW'(1)) begin
          state_d = DONE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      data      <= RESET_VAL;
      remaining <= '0;
      mode      <= M_LOAD;
    end else begin
      state     <= state_d;
      data      <= data_d;
      remaining <= rem_d;
      mode      <= mode_d;
    end
  end

  assign cmd_ready = (state == IDLE);
  assign busy      = !cmd_ready;
  assign done      = (state == DONE);
  assign p_out     = data;
  assign s_out_l   = data[WIDTH-1];
  assign s_out_r   = data[0];

endmodule

// File: tb/tb_univ_shift_reg.sv
// Bench for univ_shift_reg: directed cases then random commands,
// checked cycle by cycle against an arithmetic model of the register.
module tb_univ_shift_reg;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_mode = 2'b00;
  logic [3:0] cmd_count = 4'd0;
  logic [7:0] p_in = 8'h00;
  logic       s_in_l = 1'b0;
  logic       s_in_r = 1'b0;
  logic [7:0] p_out;
  logic       s_out_l, s_out_r, busy, done;

  int vectors = 0;
  int miscompares = 0;
  int model = 0;

`ifdef ROTATE_EN
  localparam bit ROT_EN = 1'b1;
`else
  localparam bit ROT_EN = 1'b0;
`endif

  univ_shift_reg #(.WIDTH(8), .RESET_VAL(8'h00)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_mode(cmd_mode), .cmd_count(cmd_count),
    .p_in(p_in), .s_in_l(s_in_l), .s_in_r(s_in_r),
    .p_out(p_out), .s_out_l(s_out_l), .s_out_r(s_out_r),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp_v);
    vectors++;
    assert (obs === exp_v) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // One position of movement, as plain integer arithmetic on 8 bits.
  function automatic int ref_step(input int m, input int v,
                                  input int sl, input int sr);
    case (m)
      1: return (v / 2) + sl * 128;
      2: return ((v * 2) % 256) + sr;
      3: return ROT_EN ? (v / 2) + (v % 2) * 128 : v;
      default: return v;
    endcase
  endfunction

  // Command fields that must be ignored while busy.
  task automatic junk();
    cmd_valid = 1'b1;
    cmd_mode  = 2'b00;
    p_in      = 8'($urandom);
    cmd_count = 4'($urandom);
  endtask

  task automatic do_cmd(input int m, input int n, input int d,
                        input int sl, input int sr);
    bit moves;
    cmd_valid = 1'b1;
    cmd_mode  = 2'(m);
    cmd_count = 4'(n);
    p_in      = 8'(d);
    chk("ready_idle", cmd_ready, 1);
    chk("busy_idle", busy, 0);
    moves = (m != 0) && (n != 0) && (ROT_EN || m != 3);
    if (m == 0) model = d;
    tick();
    junk();
    for (int i = 0; i < (moves ? n : 0); i++) begin
      chk("busy_shift", busy, 1);
      chk("done_shift", done, 0);
      chk("ready_shift", cmd_ready, 0);
      chk("p_out_step", p_out, model);
      s_in_l = (sl < 0) ? 1'($urandom) : 1'(sl);
      s_in_r = (sr < 0) ? 1'($urandom) : 1'(sr);
      model = ref_step(m, model, int'(s_in_l), int'(s_in_r));
      tick();
      junk();
    end
    chk("done_pulse", done, 1);
    chk("busy_done", busy, 1);
    chk("p_out_done", p_out, model);
    chk("s_out_l", s_out_l, model / 128);
    chk("s_out_r", s_out_r, model % 2);
    tick();
    chk("done_clear", done, 0);
    chk("ready_back", cmd_ready, 1);
    chk("p_out_hold", p_out, model);
    cmd_valid = 1'b0;
  endtask

  initial begin
    // Reset held for two edges.
    rst = 1'b0;
    tick();
    tick();
    chk("rst_p_out", p_out, 0);
    chk("rst_done", done, 0);
    rst = 1'b1;
    tick();
    chk("rst_ready", cmd_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_p_out2", p_out, 0);
    model = 0;

    do_cmd(0, 0, 'hA5, 0, 0);
    chk("load_a5", p_out, 'hA5);
    do_cmd(1, 3, 0, 1, 0);
    chk("shr3_f4", p_out, 'hF4);
    do_cmd(0, 0, 'hA5, 0, 0);
    do_cmd(2, 2, 0, 1, 0);
    chk("shl2_94", p_out, 'h94);
    do_cmd(1, 0, 0, 1, 1);
    chk("cnt0_hold", p_out, 'h94);
    do_cmd(2, 12, 0, 1, 1);
    chk("refill_ff", p_out, 'hFF);
    do_cmd(0, 0, 'hA5, 0, 0);
    do_cmd(3, 1, 0, 0, 0);
    chk("mode11", p_out, ROT_EN ? 'hD2 : 'hA5);

    // Reset mid-shift aborts without a done pulse.
    do_cmd(0, 0, 'hFF, 0, 0);
    cmd_valid = 1'b1;
    cmd_mode  = 2'b01;
    cmd_count = 4'd5;
    s_in_l    = 1'b0;
    tick();
    cmd_valid = 1'b0;
    tick();
    tick();
    chk("abort_mid", p_out, 'h3F);
    rst = 1'b0;
    tick();
    chk("abort_p_out", p_out, 0);
    chk("abort_done", done, 0);
    rst = 1'b1;
    tick();
    chk("abort_ready", cmd_ready, 1);
    chk("abort_done2", done, 0);
    model = 0;

    for (int k = 0; k < 150; k++) begin
      do_cmd(int'($urandom_range(0, 3)), int'($urandom_range(0, 10)),
             int'($urandom_range(0, 255)), -1, -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
